adc_frame_collector: RTL and testbench

Downstream consumer of the ADC FIFO chain: accepts the word stream leaving the last `adc_register` stage, one word per clock, with no backpressure. Each valid word is tagged with its channel index, and whole frames are buffered in a small synchronous FIFO. Buffered frames are presented on a valid/ready stream to the acquisition/DMA logic. The block detects two faults: frames dropped because the buffer lacks room, and short (truncated) frames.

---
 rtl/adc_frame_collector_pkg.sv | 19 +
 rtl/adc_sync_fifo.sv | 80 ++++++++
 rtl/adc_frame_collector.sv | 129 ++++++++++++
 tb/tb_adc_frame_collector.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_collector_pkg.sv
// Shared constants and entry-layout helper for the ADC frame collector.
// Optional frame tagging is enabled by defining ADC_COLLECT_FRAME_TAG_EN.
package adc_frame_collector_pkg;

  localparam int ADC_BITS_DEF     = 24;
  localparam int NUM_CHANNELS_DEF = 8;
  localparam int FIFO_DEPTH_DEF   = 16;
  localparam int FRAME_TAG_W      = 8;

  // Buffered entry layout is {frame?, last, chan, data}.
  function automatic int entry_width(input int adc_bits, input int chan_w);
`ifdef ADC_COLLECT_FRAME_TAG_EN
    return FRAME_TAG_W + 1 + chan_w + adc_bits;
`else
    return 1 + chan_w + adc_bits;
`endif
  endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// Occupancy and free count include the word held in the output register.
module adc_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [AW:0]      free_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      mcnt_q, mcnt_d, cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             load, from_mem, bypass, mem_wr;

  // An empty output stage takes the incoming word directly, giving one-cycle latency.
  always_comb begin
    load     = !valid_q || pop_i;
    from_mem = load && (mcnt_q != '0);
    bypass   = load && (mcnt_q == '0) && push_i;
    mem_wr   = push_i && !bypass;

    wr_ptr_d = mem_wr   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = from_mem ? rd_ptr_q + AW'(1) : rd_ptr_q;

    mcnt_d = mcnt_q;
    if (mem_wr)   mcnt_d = mcnt_d + (AW+1)'(1);
    if (from_mem) mcnt_d = mcnt_d - (AW+1)'(1);

    cnt_d = cnt_q;
    if (push_i)             cnt_d = cnt_d + (AW+1)'(1);
    if (valid_q && pop_i)   cnt_d = cnt_d - (AW+1)'(1);

    rdata_d = rdata_q;
    if (from_mem)    rdata_d = mem_q[rd_ptr_q];
    else if (bypass) rdata_d = wdata_i;

    valid_d = load ? (from_mem || bypass) : valid_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mcnt_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mcnt_q   <= mcnt_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_wr) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign valid_o = valid_q;
  assign full_o  = (cnt_q == DEPTH_C);
  assign free_o  = DEPTH_C - cnt_q;

endmodule

// File: rtl/adc_frame_collector.sv
// Tags ADC chain words with channel index and buffers whole frames for DMA.
// Define ADC_COLLECT_FRAME_TAG_EN to add the 8-bit out_frame sequence tag.
module adc_frame_collector
  import adc_frame_collector_pkg::*;
#(
  parameter int ADC_BITS     = ADC_BITS_DEF,
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  localparam int CHAN_W      = $clog2(NUM_CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADC_BITS:0]   chain_in,
  output logic [ADC_BITS-1:0] out_data,
  output logic [CHAN_W-1:0]   out_chan,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic                frame_error,
`ifdef ADC_COLLECT_FRAME_TAG_EN
  output logic [FRAME_TAG_W-1:0] out_frame,
`endif
  input  logic                clear_errors
);

  localparam int ENTRY_W = entry_width(ADC_BITS, CHAN_W);
  localparam int FAW     = $clog2(FIFO_DEPTH);
  localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(NUM_CHANNELS - 1);
  localparam logic [FAW:0]      NCH_C   = (FAW+1)'(NUM_CHANNELS);

  logic [CHAN_W-1:0]  chan_cnt_q, chan_cnt_d;
  logic               drop_q, drop_d;
  logic               overflow_q, overflow_d;
  logic               ferr_q, ferr_d;
  logic               word_vld, start, accept, drop_now, push, last, short_frame;
  logic [ENTRY_W-1:0] wdata, rdata;
  logic               fifo_full;
  logic [FAW:0]       fifo_free;

  always_comb begin
    word_vld    = chain_in[ADC_BITS];
    start       = word_vld && (chan_cnt_q == '0);
    accept      = (fifo_free >= NCH_C);
    drop_now    = start ? !accept : drop_q;
    last        = (chan_cnt_q == LAST_CH);
    push        = word_vld && !drop_now && !fifo_full;
    short_frame = !word_vld && (chan_cnt_q != '0);

    chan_cnt_d = '0;
    drop_d     = 1'b0;
    if (word_vld && !last) begin
      chan_cnt_d = chan_cnt_q + CHAN_W'(1);
      drop_d     = drop_now;
    end

    // A set event in the same cycle as clear_errors takes priority.
    overflow_d = overflow_q;
    ferr_d     = ferr_q;
    if (clear_errors) begin
      overflow_d = 1'b0;
      ferr_d     = 1'b0;
    end
    if (start && !accept) overflow_d = 1'b1;
    if (short_frame)      ferr_d     = 1'b1;
  end

`ifdef ADC_COLLECT_FRAME_TAG_EN
  logic [FRAME_TAG_W-1:0] frame_q, frame_d, cur_tag_q, cur_tag_d, wtag;

  // The tag advances on every frame start, so dropped frames leave visible gaps.
  always_comb begin
    wtag      = start ? frame_q : cur_tag_q;
    frame_d   = start ? frame_q + FRAME_TAG_W'(1) : frame_q;
    cur_tag_d = wtag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q   <= '0;
      cur_tag_q <= '0;
    end else begin
      frame_q   <= frame_d;
      cur_tag_q <= cur_tag_d;
    end
  end

  assign wdata     = {wtag, last, chan_cnt_q, chain_in[ADC_BITS-1:0]};
  assign out_frame = rdata[ENTRY_W-1 -: FRAME_TAG_W];
`else
  assign wdata = {last, chan_cnt_q, chain_in[ADC_BITS-1:0]};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      chan_cnt_q <= '0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      chan_cnt_q <= chan_cnt_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      ferr_q     <= ferr_d;
    end
  end

  adc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (out_ready),
    .rdata_o (rdata),
    .valid_o (out_valid),
    .full_o  (fifo_full),
    .free_o  (fifo_free)
  );

  assign out_data    = rdata[ADC_BITS-1:0];
  assign out_chan    = rdata[ADC_BITS +: CHAN_W];
  assign out_last    = rdata[ADC_BITS + CHAN_W];
  assign overflow    = overflow_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_adc_frame_collector.sv
// Scoreboard bench for adc_frame_collector: directed frames, overflow, short frames, reset.
module tb_adc_frame_collector;

  localparam int ADC_BITS = 24;
  localparam int NCH      = 8;

  typedef struct {
    logic [23:0] data;
    logic [2:0]  chan;
    logic        last;
    logic [7:0]  tag;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADC_BITS:0] chain_in = '0;
  logic [23:0]       out_data;
  logic [2:0]        out_chan;
  logic              out_last, out_valid, overflow, frame_error;
  logic              out_ready = 1'b1;
  logic              clear_errors = 1'b0;
  logic [7:0]        out_frame_w;

  int   checks = 0;
  int   failures = 0;
  int   rx_count = 0;
  exp_t expq[$];

  always #5 clock = ~clock;

  adc_frame_collector dut (
    .clock        (clock),
    .reset        (reset),
    .chain_in     (chain_in),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .frame_error  (frame_error),
`ifdef ADC_COLLECT_FRAME_TAG_EN
    .out_frame    (out_frame_w),
`endif
    .clear_errors (clear_errors)
  );

`ifndef ADC_COLLECT_FRAME_TAG_EN
  assign out_frame_w = 8'h00;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic exp_push(input logic [23:0] d, input int ch, input int tag);
    exp_t e;
    e.data = d;
    e.chan = 3'(ch);
    e.last = (ch == NCH - 1);
    e.tag  = 8'(tag);
    expq.push_back(e);
  endtask

  task automatic send_word(input logic v, input logic [23:0] d);
    chain_in = {v, d};
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_word(1'b0, 24'h0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, 64'(expq.size()), 64'd0);
    idle(2);
  endtask

  // Monitor: every accepted output word is compared to the head of the queue.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h expected=none", out_data);
      end else begin
        exp_t e;
        e = expq.pop_front();
        rx_count++;
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_chan", 64'(out_chan), 64'(e.chan));
        check("out_last", 64'(out_last), 64'(e.last));
`ifdef ADC_COLLECT_FRAME_TAG_EN
        check("out_frame", 64'(out_frame_w), 64'(e.tag));
`endif
      end
    end
  end

  initial begin
    int rx0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 0);
    check("rst_data", 64'(out_data), 0);
    check("rst_chan", 64'(out_chan), 0);
    check("rst_last", 64'(out_last), 0);
    check("rst_ovf", 64'(overflow), 0);
    check("rst_ferr", 64'(frame_error), 0);
    check("rst_frame", 64'(out_frame_w), 0);

    // One frame 1..8, tag 0; first output one cycle after first input.
    for (int i = 0; i < NCH; i++) begin
      exp_push(24'(i + 1), i, 0);
      send_word(1'b1, 24'(i + 1));
      if (i == 0) begin
        check("latency_valid", 64'(out_valid), 1);
        check("latency_data", 64'(out_data), 1);
      end
    end
    idle(1);
    wait_drain("drain_frame1");
    check("f1_ovf", 64'(overflow), 0);
    check("f1_ferr", 64'(frame_error), 0);

    // Two back-to-back frames, tags 1 and 2.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NCH; i++) begin
        exp_push(24'h10 * (f + 1) + 24'(i), i, 1 + f);
        send_word(1'b1, 24'h10 * (f + 1) + 24'(i));
      end
    idle(1);
    wait_drain("drain_b2b");

    // Stalled consumer: frames tagged 3,4 buffered, frame 5 dropped.
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NCH; i++) begin
        if (f < 2) exp_push(24'h100 * (f + 1) + 24'(i), i, 3 + f);
        send_word(1'b1, 24'h100 * (f + 1) + 24'(i));
      end
    idle(1);
    check("ovf_set", 64'(overflow), 1);
    check("ovf_ferr", 64'(frame_error), 0);
    rx0 = rx_count;
    out_ready = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_drain_count", 64'(rx_count - rx0), 16);
    check("ovf_empty", 64'(out_valid), 0);

    // Short frame of 5 words (tag 6), then a full frame (tag 7).
    for (int i = 0; i < 5; i++) begin
      exp_push(24'h400 + 24'(i), i, 6);
      send_word(1'b1, 24'h400 + 24'(i));
    end
    send_word(1'b0, 24'h0);
    check("short_ferr", 64'(frame_error), 1);
    for (int i = 0; i < NCH; i++) begin
      exp_push(24'h500 + 24'(i), i, 7);
      send_word(1'b1, 24'h500 + 24'(i));
    end
    idle(1);
    wait_drain("drain_short");

    // clear_errors alone clears both flags.
    clear_errors = 1'b1;
    send_word(1'b0, 24'h0);
    clear_errors = 1'b0;
    check("clr_ovf", 64'(overflow), 0);
    check("clr_ferr", 64'(frame_error), 0);

    // Short detection in the same cycle as clear_errors: set wins (tag 8).
    exp_push(24'h600, 0, 8);
    send_word(1'b1, 24'h600);
    exp_push(24'h601, 1, 8);
    send_word(1'b1, 24'h601);
    clear_errors = 1'b1;
    send_word(1'b0, 24'h0);
    clear_errors = 1'b0;
    check("clr_vs_set_ferr", 64'(frame_error), 1);
    clear_errors = 1'b1;
    send_word(1'b0, 24'h0);
    clear_errors = 1'b0;
    check("clr2_ferr", 64'(frame_error), 0);
    wait_drain("drain_clr");

    // Reset mid-frame after 3 words; buffered words are discarded.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(1'b1, 24'h700 + 24'(i));
    chain_in = '0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    expq.delete();
    check("mrst_valid", 64'(out_valid), 0);
    check("mrst_data", 64'(out_data), 0);
    check("mrst_chan", 64'(out_chan), 0);
    check("mrst_last", 64'(out_last), 0);
    check("mrst_ferr", 64'(frame_error), 0);
    check("mrst_frame", 64'(out_frame_w), 0);
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      exp_push(24'h800 + 24'(i), i, 0);
      send_word(1'b1, 24'h800 + 24'(i));
    end
    idle(1);
    wait_drain("drain_rst");
    check("post_rst_ferr", 64'(frame_error), 0);
    check("post_rst_ovf", 64'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
